rl_ram_queue_ctrl: RTL

Synchronous FIFO controller that sits directly in front of a 1-read/1-write inferrable RAM. It drives the RAM write and read ports, consumes the RAM's registered read data, and presents a valid/ready pop interface. The RAM stays a separate instance (no bypass logic), so the controller owns pointers, occupancy and the 1-cycle read latency. Used for deep instruction and data queues in the RISC-V SoC.

---
 rtl/rl_ram_queue_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/rl_ram_queue_ctrl.sv
// rtl/rl_ram_queue_ctrl.sv - FIFO controller in front of a 1R/1W RAM with a 2-entry output buffer.
// Optional occupancy output count_o under RL_RAM_QUEUE_COUNT_EN.
module rl_ram_queue_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DBITS-1:0]         din_i,
  output logic                     full_o,
  output logic                     valid_o,
  input  logic                     pop_i,
  output logic [DBITS-1:0]         dout_o,
  output logic                     empty_o,
  output logic [ABITS-1:0]         ram_waddr_o,
  output logic [DBITS-1:0]         ram_din_o,
  output logic                     ram_we_o,
  output logic [(DBITS+7)/8-1:0]   ram_be_o,
  output logic [ABITS-1:0]         ram_raddr_o,
  input  logic [DBITS-1:0]         ram_dout_i
`ifdef RL_RAM_QUEUE_COUNT_EN
  ,
  output logic [ABITS+1:0]         count_o
`endif
);

  localparam logic [ABITS:0] CAP = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] wptr, rptr;
  logic [ABITS:0]   ram_cnt, ram_cnt_n;
  logic             pend;
  logic [DBITS-1:0] head, skid;
  logic [1:0]       out_cnt, out_cnt_n, out_after_pop;
  logic             valid_q, full_q, empty_q;
  logic             push_fire, pop_fire, rd_go;

  always_comb begin
    push_fire     = push_i & ~full_q;
    pop_fire      = valid_q & pop_i;
    // Issue a read only if the buffer can absorb the returning word next cycle.
    rd_go         = (ram_cnt != '0) &&
                    (({1'b0, out_cnt} + {2'b00, pend}) <= (3'd1 + {2'b00, pop_fire}));
    ram_cnt_n     = ram_cnt + (ABITS+1)'(push_fire) - (ABITS+1)'(rd_go);
    out_after_pop = out_cnt - {1'b0, pop_fire};
    out_cnt_n     = out_after_pop + {1'b0, pend};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      pend    <= 1'b0;
      head    <= '0;
      skid    <= '0;
      out_cnt <= 2'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr    <= wptr + ABITS'(push_fire);
      rptr    <= rptr + ABITS'(rd_go);
      ram_cnt <= ram_cnt_n;
      pend    <= rd_go;
      out_cnt <= out_cnt_n;
      if (pop_fire)
        head <= skid;
      // Returning RAM word lands in the first free slot after this cycle's pop.
      if (pend) begin
        if (out_after_pop == 2'd0)
          head <= ram_dout_i;
        else
          skid <= ram_dout_i;
      end
      valid_q <= (out_cnt_n != 2'd0);
      full_q  <= (ram_cnt_n == CAP);
      empty_q <= (ram_cnt_n == '0) && !rd_go && (out_cnt_n == 2'd0);
    end
  end

`ifdef RL_RAM_QUEUE_COUNT_EN
  logic [ABITS+1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      count_q <= '0;
    else
      count_q <= (ABITS+2)'(ram_cnt_n) + (ABITS+2)'(rd_go) + (ABITS+2)'(out_cnt_n);
  end

  assign count_o = count_q;
`endif

  assign full_o      = full_q;
  assign valid_o     = valid_q;
  assign empty_o     = empty_q;
  assign dout_o      = head;
  assign ram_waddr_o = wptr;
  assign ram_din_o   = din_i;
  assign ram_we_o    = push_fire;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rptr;

endmodule
